// File: rtl/mcd_pkg.sv
// mcd_pkg: shared definitions for the multicycle ARM-subset datapath.
//   - state_t      : FSM state encoding, also exported on the STATE debug port
//   - OP_*         : data-processing opcodes (instruction bits [24:21])
//   - COND_*       : supported condition codes (instruction bits [31:28])
//   - FLAG_*       : bit positions of N, Z, C, V inside the 4-bit FLAGS vector
//   - dp_op_supported() : true for the data-processing opcodes we execute
package mcd_pkg;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_ADD = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b1010;
   localparam logic [3:0] OP_ORR = 4'b1100;
   localparam logic [3:0] OP_MOV = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   function automatic logic dp_op_supported(input logic [3:0] op);
      case (op)
         OP_AND, OP_SUB, OP_ADD, OP_CMP, OP_ORR, OP_MOV: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mcd_regfile.sv
// mcd_regfile: NREGS x WIDTH register file, two asynchronous read ports and
// one synchronous write port; all entries cleared by the active-low reset.
//   clk, rst_n         : clock, asynchronous active-low reset
//   ra1/rd1, ra2/rd2   : read address / data
//   we, wa, wd         : write enable / address / data
module mcd_regfile #(
   parameter  int unsigned WIDTH = 32,
   parameter  int unsigned NREGS = 16,
   localparam int unsigned RW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [RW-1:0]    ra1,
   input  logic [RW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   input  logic             we,
   input  logic [RW-1:0]    wa,
   input  logic [WIDTH-1:0] wd
);

   logic [WIDTH-1:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = regs[ra1];
   assign rd2 = regs[ra2];

endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: multicycle ARM-subset core with a single shared memory
// port. Executes ADD/SUB/AND/ORR/MOV/CMP (reg or imm8), LDR/STR (imm12 word)
// and B, with EQ/NE/AL conditions.
//   CLK, RESET (async active-low)
//   MEM_REQ/MEM_WE/MEM_ADDR/MEM_WDATA : request held until MEM_READY
//   MEM_RDATA/MEM_READY               : fetch/load data, completion strobe
//   OUT   : last value written to a register (ALU result or load data)
//   FLAGS : NZCV
//   STATE : current FSM state (debug)
// Optional feature: define MCD_BRANCH_LINK_EN to make B with L=1 write the
// return address into register NREGS-2.
module multicycle_datapath
   import mcd_pkg::*;
#(
   parameter int unsigned     WIDTH    = 32,
   parameter int unsigned     NREGS    = 16,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             CLK,
   input  logic             RESET,
   output logic             MEM_REQ,
   output logic             MEM_WE,
   output logic [WIDTH-1:0] MEM_ADDR,
   output logic [WIDTH-1:0] MEM_WDATA,
   input  logic [WIDTH-1:0] MEM_RDATA,
   input  logic             MEM_READY,
   output logic [WIDTH-1:0] OUT,
   output logic [3:0]       FLAGS,
   output logic [3:0]       STATE
);

   localparam int unsigned   RW     = (NREGS > 1) ? $clog2(NREGS) : 1;
   localparam logic [RW-1:0] PC_IDX = RW'(NREGS - 1);
`ifdef MCD_BRANCH_LINK_EN
   localparam logic [RW-1:0] LR_IDX = RW'(NREGS - 2);
`endif

   state_t           state, state_nx;
   logic [31:0]      ir;
   logic [WIDTH-1:0] pc, a, b, aluout, data;

   logic [3:0]       opcode;
   logic [RW-1:0]    rn, rd, rm, rb;
   logic             cond_ok, is_dp, is_mem, is_br;

   logic [WIDTH-1:0] rf_rd1, rf_rd2, rf_wdata;
   logic [RW-1:0]    rf_waddr;
   logic             rf_we;

   logic [WIDTH-1:0] op2, alu_res, imm12, br_off;
   logic [WIDTH:0]   sum, diff;
   logic             alu_c, alu_v;
   logic [3:0]       flags_nx;

   assign opcode = ir[24:21];
   assign rn     = RW'(ir[19:16]);
   assign rd     = RW'(ir[15:12]);
   assign rm     = RW'(ir[3:0]);
   // Second read port serves Rm for data processing, Rd (store data) otherwise.
   assign rb     = (ir[27:26] == 2'b00) ? rm : rd;
   assign imm12  = WIDTH'(ir[11:0]);
   assign br_off = WIDTH'($signed({ir[23:0], 2'b00}));
   assign STATE  = state;

   mcd_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
      .clk   (CLK),
      .rst_n (RESET),
      .ra1   (rn),
      .ra2   (rb),
      .rd1   (rf_rd1),
      .rd2   (rf_rd2),
      .we    (rf_we),
      .wa    (rf_waddr),
      .wd    (rf_wdata)
   );

   // Instruction classification; only meaningful while in DECODE.
   always_comb begin
      case (ir[31:28])
         COND_EQ: cond_ok = FLAGS[FLAG_Z];
         COND_NE: cond_ok = ~FLAGS[FLAG_Z];
         COND_AL: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
      // Rotated immediates and shifted registers are not supported.
      is_dp  = (ir[27:26] == 2'b00) && dp_op_supported(opcode) &&
               (ir[25] ? (ir[11:8] == 4'd0) : (ir[11:4] == 8'd0));
      is_mem = (ir[27:26] == 2'b01) && !ir[25] && !ir[22];
      is_br  = (ir[27:25] == 3'b101);
   end

   // ALU: SUB/CMP carry is ARM-style NOT borrow; logic ops and MOV keep C,V.
   always_comb begin
      op2     = (state == EXECI) ? WIDTH'(ir[7:0]) : b;
      sum     = {1'b0, a} + {1'b0, op2};
      diff    = {1'b0, a} - {1'b0, op2};
      alu_res = op2;
      alu_c   = FLAGS[FLAG_C];
      alu_v   = FLAGS[FLAG_V];
      case (opcode)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (a[WIDTH-1] == op2[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = ~diff[WIDTH];
            alu_v   = (a[WIDTH-1] != op2[WIDTH-1]) && (alu_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND:  alu_res = a & op2;
         OP_ORR:  alu_res = a | op2;
         default: alu_res = op2;
      endcase
      flags_nx         = '0;
      flags_nx[FLAG_N] = alu_res[WIDTH-1];
      flags_nx[FLAG_Z] = (alu_res == '0);
      flags_nx[FLAG_C] = alu_c;
      flags_nx[FLAG_V] = alu_v;
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) state <= FETCH;
      else        state <= state_nx;
   end

   // FSM next state
   always_comb begin
      state_nx = state;
      case (state)
         FETCH:  if (MEM_READY) state_nx = DECODE;
         DECODE: begin
            if (!cond_ok)    state_nx = FETCH;
            else if (is_br)  state_nx = BRANCH;
            else if (is_mem) state_nx = MEMADR;
            else if (is_dp)  state_nx = ir[25] ? EXECI : EXECR;
            else             state_nx = FETCH;
         end
         EXECR, EXECI: state_nx = (opcode == OP_CMP) ? FETCH : ALUWB;
         MEMADR: state_nx = ir[20] ? MEMRD : MEMWR;
         MEMRD:  if (MEM_READY) state_nx = MEMWB;
         MEMWR:  if (MEM_READY) state_nx = FETCH;
         default: state_nx = FETCH;
      endcase
   end

   // FSM outputs: memory port and register-file write port
   always_comb begin
      MEM_REQ   = 1'b0;
      MEM_WE    = 1'b0;
      MEM_ADDR  = pc;
      MEM_WDATA = '0;
      rf_we     = 1'b0;
      rf_waddr  = rd;
      rf_wdata  = aluout;
      case (state)
         // Gated with RESET so the request drops as soon as reset asserts.
         FETCH: MEM_REQ = RESET;
         MEMRD: begin
            MEM_REQ  = RESET;
            MEM_ADDR = {aluout[WIDTH-1:2], 2'b00};
         end
         MEMWR: begin
            MEM_REQ   = RESET;
            MEM_WE    = 1'b1;
            MEM_ADDR  = {aluout[WIDTH-1:2], 2'b00};
            MEM_WDATA = b;
         end
         ALUWB: rf_we = (rd != PC_IDX);
         MEMWB: begin
            rf_we    = (rd != PC_IDX);
            rf_wdata = data;
         end
`ifdef MCD_BRANCH_LINK_EN
         BRANCH: begin
            // pc already points past the branch: it is the return address.
            rf_we    = ir[24];
            rf_waddr = LR_IDX;
            rf_wdata = pc;
         end
`endif
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pc     <= RESET_PC;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         aluout <= '0;
         data   <= '0;
         OUT    <= '0;
         FLAGS  <= '0;
      end else begin
         case (state)
            FETCH: if (MEM_READY) begin
               ir <= 32'(MEM_RDATA);
               pc <= pc + WIDTH'(4);
            end
            // pc has already advanced once, so PC reads see fetch address + 8.
            DECODE: begin
               a <= (rn == PC_IDX) ? pc + WIDTH'(4) : rf_rd1;
               b <= (rb == PC_IDX) ? pc + WIDTH'(4) : rf_rd2;
            end
            EXECR, EXECI: begin
               aluout <= alu_res;
               if (ir[20] || opcode == OP_CMP) FLAGS <= flags_nx;
            end
            ALUWB: begin
               OUT <= aluout;
               if (rd == PC_IDX) pc <= {aluout[WIDTH-1:2], 2'b00};
            end
            MEMADR: aluout <= ir[23] ? a + imm12 : a - imm12;
            MEMRD:  if (MEM_READY) data <= MEM_RDATA;
            MEMWB: begin
               OUT <= data;
               if (rd == PC_IDX) pc <= {data[WIDTH-1:2], 2'b00};
            end
            BRANCH: pc <= pc + WIDTH'(4) + br_off;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_datapath.sv
// tb_multicycle_datapath: directed bench for multicycle_datapath with a word
// memory model answering the shared port after a programmable latency.
module tb_multicycle_datapath;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        MEM_REQ, MEM_WE;
   logic [31:0] MEM_ADDR, MEM_WDATA, OUT;
   logic [31:0] MEM_RDATA = '0;
   logic        MEM_READY = 1'b0;
   logic [3:0]  FLAGS, STATE;

   logic [31:0] mem [0:255];
   int unsigned ready_lat = 0;
   int unsigned wait_cnt = 0;
   int unsigned wr_count = 0;
   logic [31:0] last_wr_addr = '0;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   multicycle_datapath #(.WIDTH(32), .NREGS(16), .RESET_PC(32'h0)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .MEM_REQ   (MEM_REQ),
      .MEM_WE    (MEM_WE),
      .MEM_ADDR  (MEM_ADDR),
      .MEM_WDATA (MEM_WDATA),
      .MEM_RDATA (MEM_RDATA),
      .MEM_READY (MEM_READY),
      .OUT       (OUT),
      .FLAGS     (FLAGS),
      .STATE     (STATE)
   );

   always #5 CLK = ~CLK;

   // Memory responder: READY after ready_lat waiting cycles of a held request.
   always @(negedge CLK) begin
      if (MEM_READY) wait_cnt = 0;
      MEM_READY = 1'b0;
      if (!RESET || !MEM_REQ) begin
         wait_cnt = 0;
      end else if (wait_cnt >= ready_lat) begin
         MEM_READY = 1'b1;
         MEM_RDATA = mem[MEM_ADDR[9:2]];
         if (MEM_WE) begin
            mem[MEM_ADDR[9:2]] = MEM_WDATA;
            wr_count++;
            last_wr_addr = MEM_ADDR;
         end
      end else begin
         wait_cnt++;
      end
   end

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   task automatic reset_dut();
      RESET = 1'b0;
      repeat (2) @(posedge CLK);
      #2 RESET = 1'b1;
   endtask

   task automatic step(input int unsigned n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      // Initial reset, sampled before any clock edge.
      #1;
      n_cmp++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL rst0_req: got %b want 0", MEM_REQ); end
      n_cmp++; if (STATE !== 4'd0) begin n_err++; $display("FAIL rst0_state: got %0d want 0", STATE); end
      n_cmp++; if (OUT !== 32'h0) begin n_err++; $display("FAIL rst0_out: got %h want 0", OUT); end
      n_cmp++; if (FLAGS !== 4'h0) begin n_err++; $display("FAIL rst0_flags: got %b want 0000", FLAGS); end
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE2812007;   // ADD R2,R1,#7
      ready_lat = 0;
      reset_dut();
      step(5);
      ready_lat = 50;          // next fetch (addr 8) stalls
      step(5);
      n_cmp++; if (STATE !== 4'd0 || MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h8) begin
         n_err++; $display("FAIL rst_stall: state %0d req %b addr %h want 0/1/00000008", STATE, MEM_REQ, MEM_ADDR);
      end
      n_cmp++; if (OUT !== 32'd12) begin n_err++; $display("FAIL rst_pre_out: got %h want 0000000c", OUT); end
      #2 RESET = 1'b0;
      #1;
      n_cmp++; if (MEM_REQ !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", MEM_REQ); end
      n_cmp++; if (dut.pc !== 32'h0) begin n_err++; $display("FAIL rst_pc: got %h want 0", dut.pc); end
      n_cmp++; if (OUT !== 32'h0) begin n_err++; $display("FAIL rst_out: got %h want 0", OUT); end
      n_cmp++; if (dut.u_rf.regs[2] !== 32'h0) begin n_err++; $display("FAIL rst_r2: got %h want 0", dut.u_rf.regs[2]); end
      ready_lat = 0;
      @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      n_cmp++; if (STATE !== 4'd0 || MEM_REQ !== 1'b1 || MEM_ADDR !== 32'h0) begin
         n_err++; $display("FAIL rst_release: state %0d req %b addr %h want 0/1/00000000", STATE, MEM_REQ, MEM_ADDR);
      end
   endtask

   task automatic test_alu_seq();
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE2812007;   // ADD R2,R1,#7
      ready_lat = 0;
      reset_dut();
      step(7);
      n_cmp++; if (STATE !== 4'd8 || dut.u_rf.regs[2] !== 32'h0) begin
         n_err++; $display("FAIL alu_c7: state %0d r2 %h want 8/00000000", STATE, dut.u_rf.regs[2]);
      end
      step(1);
      n_cmp++; if (dut.u_rf.regs[2] !== 32'd12) begin n_err++; $display("FAIL alu_r2: got %h want 0000000c", dut.u_rf.regs[2]); end
      n_cmp++; if (OUT !== 32'd12) begin n_err++; $display("FAIL alu_out: got %h want 0000000c", OUT); end
      n_cmp++; if (dut.u_rf.regs[1] !== 32'd5) begin n_err++; $display("FAIL alu_r1: got %h want 00000005", dut.u_rf.regs[1]); end
      n_cmp++; if (STATE !== 4'd0 || dut.pc !== 32'h8) begin
         n_err++; $display("FAIL alu_c8: state %0d pc %h want 0/00000008", STATE, dut.pc);
      end
   endtask

   task automatic test_branch_eq();
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE0513001;   // SUBS R3,R1,R1
      mem[2] = 32'h0A000001;   // BEQ to 0x08+8+4 = 0x14, skipping 0x0C and 0x10
      ready_lat = 0;
      reset_dut();
      step(4);
      n_cmp++; if (FLAGS !== 4'b0000) begin n_err++; $display("FAIL beq_mov_flags: got %b want 0000", FLAGS); end
      step(4);
      n_cmp++; if (FLAGS !== 4'b0110) begin n_err++; $display("FAIL beq_subs_flags: got %b want 0110", FLAGS); end
      n_cmp++; if (dut.u_rf.regs[3] !== 32'h0 || OUT !== 32'h0) begin
         n_err++; $display("FAIL beq_r3: r3 %h out %h want 0/0", dut.u_rf.regs[3], OUT);
      end
      step(3);
      n_cmp++; if (STATE !== 4'd0 || dut.pc !== 32'h14 || MEM_ADDR !== 32'h14) begin
         n_err++; $display("FAIL beq_target: state %0d pc %h addr %h want 0/00000014", STATE, dut.pc, MEM_ADDR);
      end
   endtask

   task automatic test_branch_ne();
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE0513001;   // SUBS R3,R1,R1
      mem[2] = 32'h1A000001;   // BNE, not taken since Z=1
      ready_lat = 0;
      reset_dut();
      step(9);
      n_cmp++; if (STATE !== 4'd1) begin n_err++; $display("FAIL bne_decode: state %0d want 1", STATE); end
      step(1);
      n_cmp++; if (STATE !== 4'd0 || dut.pc !== 32'hC) begin
         n_err++; $display("FAIL bne_fall: state %0d pc %h want 0/0000000c", STATE, dut.pc);
      end
   endtask

   task automatic test_mem_stall();
      int unsigned wr_cycles = 0, rd_cycles = 0, unstable = 0, we_bad = 0;
      logic [31:0] p_addr = '0, p_wdata = '0, seen_wr_addr = '0, seen_wr_data = '0;
      logic        p_we = 1'b0;
      logic [3:0]  p_state = 4'hF;
      bit          done = 1'b0;
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE2812007;   // ADD R2,R1,#7
      mem[2] = 32'hE5802040;   // STR R2,[R0,#64]
      mem[3] = 32'hE5904040;   // LDR R4,[R0,#64]
      ready_lat = 3;
      wr_count = 0;
      reset_dut();
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(negedge CLK);
         if (STATE == 4'd5 && MEM_WE) begin
            wr_cycles++;
            seen_wr_addr = MEM_ADDR;
            seen_wr_data = MEM_WDATA;
         end
         if (STATE == 4'd3) rd_cycles++;
         if (MEM_WE && STATE != 4'd5) we_bad++;
         if (MEM_REQ && STATE == p_state && (MEM_ADDR !== p_addr || MEM_WE !== p_we || MEM_WDATA !== p_wdata)) unstable++;
         p_state = STATE; p_addr = MEM_ADDR; p_we = MEM_WE; p_wdata = MEM_WDATA;
         if (STATE == 4'd0 && dut.pc == 32'h10) done = 1'b1;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL mem_timeout: got done=%b want 1", done); end
      n_cmp++; if (wr_cycles !== 4) begin n_err++; $display("FAIL mem_wr_cycles: got %0d want 4", wr_cycles); end
      n_cmp++; if (rd_cycles !== 4) begin n_err++; $display("FAIL mem_rd_cycles: got %0d want 4", rd_cycles); end
      n_cmp++; if (we_bad !== 0) begin n_err++; $display("FAIL mem_we_outside_store: got %0d want 0", we_bad); end
      n_cmp++; if (unstable !== 0) begin n_err++; $display("FAIL mem_bus_stable: got %0d changes want 0", unstable); end
      n_cmp++; if (seen_wr_addr !== 32'h40 || seen_wr_data !== 32'd12) begin
         n_err++; $display("FAIL mem_str_bus: addr %h data %h want 00000040/0000000c", seen_wr_addr, seen_wr_data);
      end
      n_cmp++; if (wr_count !== 1 || last_wr_addr !== 32'h40 || mem[16] !== 32'd12) begin
         n_err++; $display("FAIL mem_store: count %0d addr %h word %h want 1/00000040/0000000c", wr_count, last_wr_addr, mem[16]);
      end
      n_cmp++; if (dut.u_rf.regs[4] !== 32'd12) begin n_err++; $display("FAIL mem_r4: got %h want 0000000c", dut.u_rf.regs[4]); end
      n_cmp++; if (OUT !== 32'd12) begin n_err++; $display("FAIL mem_out: got %h want 0000000c", OUT); end
      ready_lat = 0;
   endtask

   task automatic test_flags();
      clear_mem();
      mem[0]  = 32'hE5905080;  // LDR R5,[R0,#0x80]
      mem[1]  = 32'hE2956001;  // ADDS R6,R5,#1
      mem[2]  = 32'hE3957000;  // ORRS R7,R5,#0
      mem[32] = 32'hFFFFFFFF;
      ready_lat = 0;
      reset_dut();
      step(5);
      n_cmp++; if (dut.u_rf.regs[5] !== 32'hFFFFFFFF || OUT !== 32'hFFFFFFFF) begin
         n_err++; $display("FAIL flg_ldr: r5 %h out %h want ffffffff", dut.u_rf.regs[5], OUT);
      end
      step(4);
      n_cmp++; if (OUT !== 32'h0 || dut.u_rf.regs[6] !== 32'h0) begin
         n_err++; $display("FAIL flg_adds_res: out %h r6 %h want 0/0", OUT, dut.u_rf.regs[6]);
      end
      n_cmp++; if (FLAGS !== 4'b0110) begin n_err++; $display("FAIL flg_adds: got %b want 0110", FLAGS); end
      step(4);
      n_cmp++; if (FLAGS !== 4'b1010) begin n_err++; $display("FAIL flg_orrs: got %b want 1010", FLAGS); end
      n_cmp++; if (dut.u_rf.regs[7] !== 32'hFFFFFFFF) begin n_err++; $display("FAIL flg_r7: got %h want ffffffff", dut.u_rf.regs[7]); end
   endtask

   task automatic test_cmp_pcwrite();
      clear_mem();
      mem[0] = 32'hE3A01005;   // MOV R1,#5
      mem[1] = 32'hE3510005;   // CMP R1,#5
      mem[2] = 32'hE3A0F022;   // MOV R15,#0x22 -> PC 0x20
      ready_lat = 0;
      reset_dut();
      step(7);
      n_cmp++; if (STATE !== 4'd0 || dut.pc !== 32'h8) begin
         n_err++; $display("FAIL cmp_latency: state %0d pc %h want 0/00000008", STATE, dut.pc);
      end
      n_cmp++; if (FLAGS !== 4'b0110) begin n_err++; $display("FAIL cmp_flags: got %b want 0110", FLAGS); end
      n_cmp++; if (OUT !== 32'd5 || dut.u_rf.regs[0] !== 32'h0) begin
         n_err++; $display("FAIL cmp_nowrite: out %h r0 %h want 00000005/0", OUT, dut.u_rf.regs[0]);
      end
      step(4);
      n_cmp++; if (dut.pc !== 32'h20 || MEM_ADDR !== 32'h20) begin
         n_err++; $display("FAIL pc_write: pc %h addr %h want 00000020", dut.pc, MEM_ADDR);
      end
   endtask

   task automatic test_link();
      logic [31:0] exp_lr;
`ifdef MCD_BRANCH_LINK_EN
      exp_lr = 32'h14;
`else
      exp_lr = 32'h33;
`endif
      clear_mem();
      mem[0] = 32'hE3A0E033;   // MOV R14,#0x33
      mem[1] = 32'hEA000001;   // B  0x04 -> 0x10
      mem[4] = 32'hEB000002;   // BL 0x10 -> 0x20
      ready_lat = 0;
      reset_dut();
      step(4);
      n_cmp++; if (dut.u_rf.regs[14] !== 32'h33) begin n_err++; $display("FAIL lnk_mov: got %h want 00000033", dut.u_rf.regs[14]); end
      step(3);
      n_cmp++; if (dut.pc !== 32'h10) begin n_err++; $display("FAIL lnk_b: pc %h want 00000010", dut.pc); end
      step(3);
      n_cmp++; if (dut.pc !== 32'h20 || STATE !== 4'd0) begin
         n_err++; $display("FAIL lnk_bl: pc %h state %0d want 00000020/0", dut.pc, STATE);
      end
      n_cmp++; if (dut.u_rf.regs[14] !== exp_lr) begin n_err++; $display("FAIL lnk_r14: got %h want %h", dut.u_rf.regs[14], exp_lr); end
   endtask

   initial begin
      test_reset();
      test_alu_seq();
      test_branch_eq();
      test_branch_ne();
      test_mem_stall();
      test_flags();
      test_cmp_pcwrite();
      test_link();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
